// File: rtl/crc_parallel.sv
// Runtime-programmable CRC engine: one DWIDTH-bit word per request, folded through
// an unrolled MSB-first per-bit chain in a single clock, result registered on the next edge.
module crc_parallel #(
    parameter int CRC_GPW_MAX = 8,
    parameter int DWIDTH      = 16
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic                   ctrlEn,
    input  logic [DWIDTH-1:0]      dataIn,
    input  logic [CRC_GPW_MAX-1:0] GenPoly,
    output logic [CRC_GPW_MAX-1:0] crcSeq,
    output logic                   crcReady
);

    localparam int TMP_WIDTH = DWIDTH * CRC_GPW_MAX;

    typedef enum logic {
        IDLE,
        CALC
    } stateType;

    stateType                 state;
    logic [DWIDTH-1:0]        dataReg;
    logic [CRC_GPW_MAX-1:0]   polyReg;
    logic [TMP_WIDTH-1:0]     stageBus;
    logic [CRC_GPW_MAX-1:0]   crcRun;
    logic                     fb;
    logic [CRC_GPW_MAX-1:0]   crcNext;

    // Stage k's remainder lands in stageBus[k*W +: W]; the last slice is the result.
    always_comb begin
        // NOTE: blocking assignments here chain each stage into the next within one
        // evaluation; every variable gets a default first so no latch is inferred.
        stageBus = '0;
        crcRun   = '0;
        fb       = 1'b0;
        for (int k = 0; k < DWIDTH; k++) begin
            fb     = crcRun[CRC_GPW_MAX-1] ^ dataReg[DWIDTH-1-k];
            crcRun = {crcRun[CRC_GPW_MAX-2:0], 1'b0} ^ (fb ? polyReg : '0);
            stageBus[k*CRC_GPW_MAX +: CRC_GPW_MAX] = crcRun;
        end
    end

    assign crcNext = stageBus[TMP_WIDTH-1 -: CRC_GPW_MAX];

    // Operands are captured only on the IDLE->CALC edge, so input churn during CALC is harmless.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= IDLE;
            dataReg  <= '0;
            polyReg  <= '0;
            crcSeq   <= '0;
            crcReady <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (ctrlEn) begin
                        dataReg  <= dataIn;
                        polyReg  <= GenPoly;
                        crcReady <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    crcSeq   <= crcNext;
                    crcReady <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc_parallel.sv
// Self-checking bench for crc_parallel: polynomial long-division reference model,
// per-cycle output comparison, directed corner cases and randomized requests.
module tb_crc_parallel;

    localparam int W = 8;
    localparam int D = 16;

    logic         clk = 1'b0;
    logic         rstN = 1'b0;
    logic         ctrlEn = 1'b0;
    logic [D-1:0] dataIn = '0;
    logic [W-1:0] GenPoly = '0;
    logic [W-1:0] crcSeq;
    logic         crcReady;

    int nChecks = 0;
    int nFails  = 0;
    int riseCount = 0;
    bit compareOn = 1'b0;

    // Model state: what the outputs must be, derived from the request/response rules.
    logic [W-1:0] expSeq;
    logic         expReady;
    logic         expBusy;
    logic [D-1:0] expData;
    logic [W-1:0] expPoly;
    int           expRise = 0;

    crc_parallel #(.CRC_GPW_MAX(W), .DWIDTH(D)) dut (
        .clk(clk), .rstN(rstN), .ctrlEn(ctrlEn), .dataIn(dataIn),
        .GenPoly(GenPoly), .crcSeq(crcSeq), .crcReady(crcReady)
    );

    always #5 clk = ~clk;

    // Remainder of (d * x^W) divided by (x^W + p), by textbook long division.
    function automatic logic [W-1:0] refCrc(input logic [D-1:0] d, input logic [W-1:0] p);
        logic [D+W-1:0] r;
        logic [W:0]     g;
        r = {d, {W{1'b0}}};
        g = {1'b1, p};
        for (int i = D + W - 1; i >= W; i--)
            if (r[i]) r[i -: W+1] = r[i -: W+1] ^ g;
        return r[W-1:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            expSeq   <= '0;
            expReady <= 1'b1;
            expBusy  <= 1'b0;
            expData  <= '0;
            expPoly  <= '0;
        end else if (expBusy) begin
            expSeq   <= refCrc(expData, expPoly);
            expReady <= 1'b1;
            expBusy  <= 1'b0;
            expRise  <= expRise + 1;
        end else if (ctrlEn) begin
            expData  <= dataIn;
            expPoly  <= GenPoly;
            expReady <= 1'b0;
            expBusy  <= 1'b1;
        end
    end

    always @(posedge crcReady) if (rstN) riseCount++;

    always @(negedge clk) begin
        if (compareOn) begin
            check("crcReady", {31'b0, crcReady}, {31'b0, expReady});
            check("crcSeq", {24'b0, crcSeq}, {24'b0, expSeq});
        end
    end

    // One-cycle strobe, then a bounded wait for ready; leaves the bench at a negedge.
    task automatic doReq(input logic [D-1:0] d, input logic [W-1:0] p);
        @(negedge clk);
        dataIn = d; GenPoly = p; ctrlEn = 1'b1;
        @(negedge clk);
        ctrlEn = 1'b0;
        check("ready_low_in_calc", {31'b0, crcReady}, 32'd0);
        for (int i = 0; i < 10 && !crcReady; i++) @(negedge clk);
        if (!crcReady) begin
            nChecks++; nFails++;
            $display("FAIL req_timeout: crcReady stayed 0, expected 1");
        end
    endtask

    initial begin
        int riseSnap;
        logic [W-1:0] randPoly;

        // Reset held two cycles.
        repeat (2) @(negedge clk);
        check("reset_seq", {24'b0, crcSeq}, 32'h00);
        check("reset_ready", {31'b0, crcReady}, 32'd1);
        compareOn = 1'b1;
        rstN = 1'b1;
        repeat (3) @(negedge clk);
        check("no_rise_after_reset", riseCount, 0);

        doReq(16'h0102, 8'h07);
        check("crc_0102", {24'b0, crcSeq}, 32'h1B);
        check("rise_count_1", riseCount, 1);

        repeat (2) @(negedge clk);
        doReq(16'hA522, 8'h07);
        check("crc_A522", {24'b0, crcSeq}, 32'hB7);
        doReq(16'hF0E5, 8'h07);
        check("crc_F0E5", {24'b0, crcSeq}, 32'hA1);
        check("rise_count_3", riseCount, 3);

        randPoly = W'($urandom);
        doReq(16'h0000, randPoly);
        check("crc_zero_data", {24'b0, crcSeq}, 32'h00);
        doReq(16'h0001, 8'h07);
        check("crc_x8_mod_p", {24'b0, crcSeq}, 32'h07);
        doReq(16'h1234, 8'h00);
        check("crc_zero_poly", {24'b0, crcSeq}, 32'h00);

        // Operand stability: new operands and a second strobe during CALC are ignored.
        riseSnap = riseCount;
        @(negedge clk);
        dataIn = 16'h1234; GenPoly = 8'h07; ctrlEn = 1'b1;
        @(negedge clk);
        dataIn = 16'hABCD; GenPoly = 8'h31; ctrlEn = 1'b1;
        @(negedge clk);
        ctrlEn = 1'b0;
        check("stable_ready", {31'b0, crcReady}, 32'd1);
        check("stable_seq", {24'b0, crcSeq}, {24'b0, refCrc(16'h1234, 8'h07)});
        repeat (2) @(negedge clk);
        check("stable_one_rise", riseCount, riseSnap + 1);

        // Reset asserted during CALC.
        @(negedge clk);
        dataIn = 16'h5A5A; GenPoly = 8'h1D; ctrlEn = 1'b1;
        @(negedge clk);
        ctrlEn = 1'b0;
        riseSnap = riseCount;
        #1 rstN = 1'b0;
        #1;
        check("midreset_seq", {24'b0, crcSeq}, 32'h00);
        check("midreset_ready", {31'b0, crcReady}, 32'd1);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        repeat (3) @(negedge clk);
        check("midreset_no_stale", riseCount, riseSnap);
        check("midreset_seq_held", {24'b0, crcSeq}, 32'h00);
        doReq(16'h0102, 8'h07);
        check("post_reset_crc", {24'b0, crcSeq}, 32'h1B);

        // Randomized traffic, including held strobes and churning operands.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            ctrlEn  = ($urandom_range(0, 2) != 0);
            dataIn  = D'($urandom);
            GenPoly = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
        end
        @(negedge clk);
        ctrlEn = 1'b0;
        repeat (3) @(negedge clk);
        check("total_rises", riseCount, expRise);

        compareOn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/crc_parallel.md
Name: crc_parallel

Overview:
- Runtime-programmable CRC engine.
- Computes the CRC of one DWIDTH-bit data word in a single parallel step (all bits per clock), using a generator polynomial supplied on an input port.
- Used as a checksum helper beside a data path. Software or control logic pulses a start strobe, then reads the result once the ready flag rises.

Parameters:
- CRC_GPW_MAX, 8: CRC width and generator-polynomial width in bits. The x^CRC_GPW_MAX term is implicit.
- DWIDTH, 16: width of the data word processed per request.
- TMP_WIDTH, DWIDTH*CRC_GPW_MAX: width of the internal scratch bus used for the unrolled per-bit stages. It is derived and never overridden.

Ports:
- clk  input  1  clock, rising-edge active.
- rstN  input  1  reset, asynchronous, active-low.
- ctrlEn  input  1  start strobe, sampled on the rising edge of clk.
- dataIn  input  DWIDTH  message word; bit DWIDTH-1 is processed first.
- GenPoly  input  CRC_GPW_MAX  generator polynomial coefficients x^(CRC_GPW_MAX-1)..x^0. The top term is implicit (example: 8'h07 = x^8+x^2+x+1).
- crcSeq  output  CRC_GPW_MAX  registered CRC result.
- crcReady  output  1  high when idle and the result is valid; low while a computation is in flight.

Behaviour:
- The reset values below apply asynchronously on rstN low: crcSeq = 0, crcReady = 1, internal data/poly registers = 0, FSM = IDLE.
- CRC definition:
  - non-reflected, MSB-first;
  - initial remainder 0, no final XOR;
  - the result is the remainder of dataIn * x^CRC_GPW_MAX modulo (x^CRC_GPW_MAX + GenPoly).
- Per-bit stage, applied DWIDTH times in one combinational unrolled chain: fb = crc[MSB] ^ data bit; crc = (crc << 1) ^ (fb ? GenPoly : 0).
- FSM states IDLE and CALC.
  - IDLE + ctrlEn = 1 at a clock edge: latch dataIn and GenPoly, set crcReady <= 0, go to CALC. crcSeq holds its old value.
  - CALC (next edge): crcSeq <= CRC of the latched data/poly, crcReady <= 1, go to IDLE.
  - Latency: crcReady falls at edge N (ctrlEn sampled) and rises at edge N+1 with crcSeq valid. A new request may be issued on the edge after crcReady rises, so back-to-back requests are possible every 2 cycles.
- ctrlEn while in CALC is ignored: no queuing, and the latched operands are not changed.
- ctrlEn held high for multiple cycles starts a new computation each time the FSM is in IDLE, using the dataIn/GenPoly values current at that edge.
- Changes to dataIn/GenPoly outside a sampling edge have no effect on the in-flight result.
- crcSeq holds its last value indefinitely until the next completed computation.
- Reset asserted mid-computation aborts it. Outputs return to their reset values, and no result is produced after reset release.
- GenPoly = 0: the result is the low CRC_GPW_MAX bits of the message shifted left by CRC_GPW_MAX bits, which is all zeros when DWIDTH >= CRC_GPW_MAX. This is legal and needs no special case.
- Consumers detect completion by the crcReady 0->1 transition. crcReady must never glitch high during CALC, and must not pulse at reset release.

Test Plan:
- Reset: hold rstN low 2 cycles -> crcSeq = 8'h00, crcReady = 1. After release with no ctrlEn, there is no crcReady rising edge.
- GenPoly = 8'h07, dataIn = 16'h0102, one-cycle ctrlEn pulse -> crcReady low for 1 cycle, then high with crcSeq = 8'h1B.
- GenPoly = 8'h07, dataIn = 16'hA522, pulse 3 cycles after the previous request -> crcSeq = 8'hB7. Then dataIn = 16'hF0E5 -> crcSeq = 8'hA1. Exactly one crcReady rising edge per request.
- dataIn = 16'h0000, any GenPoly -> crcSeq = 8'h00. Also check dataIn = 16'h0001 with GenPoly = 8'h07 -> crcSeq = 8'h07, i.e. x^8 mod p.
- Operand stability: change dataIn and GenPoly and assert ctrlEn again during the CALC cycle -> the result matches the originally latched operands and the second strobe is ignored.
- Assert rstN low during CALC -> crcSeq = 0 and crcReady = 1 immediately. No stale result appears after reset release; a subsequent request computes correctly.
